fir_mac_sequencer: RTL and testbench
====================================

Name: fir_mac_sequencer

Overview:
Sequencer for a time-multiplexed, single-MAC FIR datapath (delay-line RAM, coefficient RAM, multiplier, accumulator).
- Per accepted input sample: writes the sample into a circular delay line, then walks all taps, issuing delay-line and coefficient read addresses and accumulator controls. Signals one output-valid pulse per result.
- Sits beside the coefficient-load FSM: computations start only once coefficients are loaded (coef_ready).

Parameters:
NTAPS, 61, number of taps / delay-line depth; 2 <= NTAPS <= 2**AW.
AW, 6, address width of delay-line and coefficient RAMs.
LAT, 2, cycles from address issue to product at the accumulator input (RAM read 1 + multiplier register 1); LAT >= 1.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
coef_ready  in  1  coefficient RAM loaded and stable.
sample_valid  in  1  one-cycle strobe: new filter_in sample available.
busy  out  1  state != IDLE.
overrun  out  1  one-cycle pulse: sample_valid dropped because busy.
dl_wren  out  1  delay-line write enable.
dl_zero  out  1  datapath writes 0 instead of the sample.
dl_waddr  out  AW  delay-line write address.
dl_raddr  out  AW  delay-line read address.
coef_raddr  out  AW  coefficient read address.
acc_clr  out  1  clear accumulator.
acc_en  out  1  accumulate current product.
out_valid  out  1  one-cycle pulse: accumulator holds the final result.

Behaviour:
- Reset (async): state=CLEAR, wptr=0, tap counter k=0, overrun=0. All outputs 0 except busy=1, dl_wren=1, dl_zero=1.
- States: CLEAR, IDLE, WRITE, MAC, FLUSH, DONE. All outputs registered or decoded from state and counters only; no input-to-output combinational paths.
- CLEAR:
  - Runs for NTAPS cycles with dl_wren=1, dl_zero=1, dl_waddr=0..NTAPS-1.
  - Then goes to IDLE with wptr=0.
  - sample_valid during CLEAR produces an overrun pulse.
- IDLE:
  - If sample_valid=1 and coef_ready=1 in cycle c0, go to WRITE.
  - If sample_valid=1 and coef_ready=0, the sample is ignored silently: no overrun, wptr unchanged.
- WRITE (cycle c0+1): dl_wren=1, dl_zero=0, dl_waddr=wptr, acc_clr=1.
- MAC (cycles c0+2 .. c0+1+NTAPS):
  - For k=0..NTAPS-1: coef_raddr=k, dl_raddr=(wptr-k) mod NTAPS.
  - The modulus is NTAPS, not 2**AW. Example: wptr=0, k=1 gives dl_raddr=NTAPS-1.
- acc_en:
  - High exactly NTAPS cycles, c0+2+LAT .. c0+1+NTAPS+LAT.
  - Driven by an LAT-deep shift of the MAC-active flag.
- FLUSH: LAT cycles to drain the pipeline; no new addresses issued (address outputs hold).
- DONE (cycle c0+2+NTAPS+LAT):
  - out_valid=1; wptr <= (wptr==NTAPS-1) ? 0 : wptr+1.
  - Next cycle: IDLE.
- Timing:
  - Latency sample_valid -> out_valid = NTAPS+LAT+2 cycles (65 at defaults).
  - Minimum accepted sample period = NTAPS+LAT+3 cycles (66).
- overrun: sample_valid=1 in any state other than IDLE produces an overrun pulse in the next cycle. The sample is dropped and the current run is unaffected.
- coef_ready falling in WRITE/MAC/FLUSH:
  - Abort to IDLE next cycle; acc_en forced 0; no out_valid.
  - wptr still advances, because the sample was already written.
- coef_ready falling in DONE: no effect; out_valid is still issued.
- Simultaneous DONE and sample_valid: the sample is an overrun (busy=1 in DONE).
- Reset asserted mid-run: immediate return to CLEAR; out_valid/acc_en/acc_clr drop asynchronously; no partial result is flagged.

Test Plan:
1. Release reset -> 61 cycles of dl_wren=1, dl_zero=1, dl_waddr 0..60 -> busy=0 in the following cycle, wptr=0.
2. Single sample at wptr=0 in cycle c0:
   - dl_waddr=0 at c0+1 with acc_clr=1.
   - coef_raddr 0..60 paired with dl_raddr 0,60,59,..,1.
   - acc_en high c0+4..c0+64; out_valid at c0+65 only.
3. sample_valid held high continuously -> accepts at c0, c0+66, c0+132; overrun pulses on every intervening cycle; exactly one out_valid per accepted sample.
4. 62 spaced samples -> dl_waddr sequence 0..60,0 (wrap at NTAPS, not 64); for sample at wptr=5, dl_raddr = 5,4,..,0,60,..,6.
5. coef_ready dropped at c0+20 -> acc_en 0 from c0+21, no out_valid, busy=0 at c0+21, next sample written at wptr+1. coef_ready=0 with sample_valid -> no accept, no overrun.
6. reset pulsed at c0+30 -> all control outputs 0 immediately (dl_wren/dl_zero/busy 1); CLEAR replays 61 cycles; next result flagged only after a fresh sample.

Source files
------------

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: control sequencer for a time-multiplexed single-MAC FIR (delay-line clear, sample write, tap walk, flush, result strobe)
// ports: clk, reset (async, active-high), coef_ready, sample_valid in; busy, overrun, dl_wren, dl_zero, dl_waddr (delay-line write),
//        dl_raddr, coef_raddr (tap reads), acc_clr, acc_en (accumulator control), out_valid (result strobe) out
module fir_mac_sequencer #(
  parameter int NTAPS = 61,
  parameter int AW = 6,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          coef_ready,
  input  logic          sample_valid,
  output logic          busy,
  output logic          overrun,
  output logic          dl_wren,
  output logic          dl_zero,
  output logic [AW-1:0] dl_waddr,
  output logic [AW-1:0] dl_raddr,
  output logic [AW-1:0] coef_raddr,
  output logic          acc_clr,
  output logic          acc_en,
  output logic          out_valid
);
  localparam logic [AW-1:0] LAST = AW'(NTAPS - 1);
  localparam int FW = LAT > 1 ? $clog2(LAT) : 1;
  localparam logic [FW-1:0] FLAST = FW'(LAT - 1);
  typedef enum logic [2:0] {CLEAR, IDLE, WRITE, MAC, FLUSH, DONE} state_t;
  state_t state, nxt;
  logic [AW-1:0] wptr, k;
  logic [FW-1:0] fc;
  logic [LAT-1:0] sh;
  logic abort;
  always_comb begin
    abort = (state == WRITE || state == MAC || state == FLUSH) && !coef_ready;
    nxt = state;
    case (state)
      CLEAR:   nxt = k == LAST ? IDLE : CLEAR;
      IDLE:    nxt = sample_valid && coef_ready ? WRITE : IDLE;
      WRITE:   nxt = MAC;
      MAC:     nxt = coef_raddr == LAST ? FLUSH : MAC;
      FLUSH:   nxt = fc == FLAST ? DONE : FLUSH;
      DONE:    nxt = IDLE;
      default: nxt = CLEAR;
    endcase
    if (abort) nxt = IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CLEAR;
      wptr       <= '0;
      k          <= '0;
      fc         <= '0;
      sh         <= '0;
      overrun    <= 1'b0;
      dl_raddr   <= '0;
      coef_raddr <= '0;
    end else begin
      state   <= nxt;
      overrun <= sample_valid && state != IDLE;
      sh      <= abort ? '0 : LAT'({sh, state == MAC});
      k       <= state == CLEAR && k != LAST ? k + 1'b1 : '0;
      fc      <= state == FLUSH ? fc + 1'b1 : '0;
      if (state == WRITE) begin
        coef_raddr <= '0;
        dl_raddr   <= wptr;
      end else if (state == MAC && coef_raddr != LAST) begin
        coef_raddr <= coef_raddr + 1'b1;
        dl_raddr   <= dl_raddr == '0 ? LAST : dl_raddr - 1'b1;
      end
      if (state == DONE || abort) wptr <= wptr == LAST ? '0 : wptr + 1'b1;
    end
  end
  assign busy      = state != IDLE;
  assign dl_wren   = state == CLEAR || state == WRITE;
  assign dl_zero   = state == CLEAR;
  assign dl_waddr  = state == CLEAR ? k : wptr;
  assign acc_clr   = state == WRITE;
  assign acc_en    = sh[LAT-1];
  assign out_valid = state == DONE;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: directed bench with a per-cycle timeline model of the FIR MAC sequencer
module tb_fir_mac_sequencer;
  localparam int NTAPS = 61;
  localparam int AW = 6;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic coef_ready = 1'b1;
  logic sample_valid = 1'b0;
  logic busy, overrun, dl_wren, dl_zero, acc_clr, acc_en, out_valid;
  logic [AW-1:0] dl_waddr, dl_raddr, coef_raddr;
  int checks = 0;
  int failures = 0;
  fir_mac_sequencer #(.NTAPS(NTAPS), .AW(AW), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .coef_ready(coef_ready), .sample_valid(sample_valid),
    .busy(busy), .overrun(overrun), .dl_wren(dl_wren), .dl_zero(dl_zero),
    .dl_waddr(dl_waddr), .dl_raddr(dl_raddr), .coef_raddr(coef_raddr),
    .acc_clr(acc_clr), .acc_en(acc_en), .out_valid(out_valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask
  int clr_left = NTAPS;
  bit act = 1'b0;
  int t = 0;
  int w = 0;
  bit e_ov = 1'b0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_left = NTAPS;
      act = 1'b0;
      t = 0;
      w = 0;
      e_ov = 1'b0;
    end else begin
      e_ov = sample_valid && (clr_left > 0 || act);
      if (clr_left > 0) clr_left--;
      else if (!act) begin
        if (sample_valid && coef_ready) begin
          act = 1'b1;
          t = 1;
        end
      end else if ((t <= NTAPS + 1 + LAT && !coef_ready) || t == NTAPS + 2 + LAT) begin
        act = 1'b0;
        w = (w + 1) % NTAPS;
      end else t++;
    end
  end
  always @(negedge clk) begin
    bit cl, ewren, mac, hold;
    cl = clr_left > 0;
    ewren = cl || (act && t == 1);
    mac = act && t >= 2 && t <= NTAPS + 1;
    hold = act && t > NTAPS + 1;
    chk("busy", busy, int'(cl || act));
    chk("overrun", overrun, int'(e_ov));
    chk("dl_wren", dl_wren, int'(ewren));
    chk("dl_zero", dl_zero, int'(cl));
    if (ewren) chk("dl_waddr", dl_waddr, cl ? NTAPS - clr_left : w);
    chk("acc_clr", acc_clr, int'(act && t == 1));
    chk("acc_en", acc_en, int'(act && t >= 2 + LAT && t <= NTAPS + 1 + LAT));
    chk("out_valid", out_valid, int'(act && t == NTAPS + 2 + LAT));
    if (cl) begin
      chk("coef_raddr_clr", coef_raddr, 0);
      chk("dl_raddr_clr", dl_raddr, 0);
    end
    if (mac) begin
      chk("coef_raddr", coef_raddr, t - 2);
      chk("dl_raddr", dl_raddr, (w - (t - 2) + NTAPS) % NTAPS);
    end
    if (hold) begin
      chk("coef_raddr_hold", coef_raddr, NTAPS - 1);
      chk("dl_raddr_hold", dl_raddr, (w + 1) % NTAPS);
    end
  end
  int lat, afirst, an, idle_at, wa1, ocnt, ac, ov, n, prev;
  int rd[0:130];
  int cf[0:130];
  task automatic one(input int abort_at);
    lat = 0; afirst = 0; an = 0; idle_at = 0; wa1 = -1; ocnt = 0;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    for (int i = 1; i <= 120; i++) begin
      if (i == abort_at) coef_ready = 1'b0;
      @(negedge clk);
      if (i == 1) wa1 = dl_waddr;
      rd[i] = dl_raddr;
      cf[i] = coef_raddr;
      if (acc_en) begin
        an++;
        if (afirst == 0) afirst = i;
      end
      if (out_valid) begin
        lat = i;
        ocnt++;
      end
      if (!busy) begin
        idle_at = i;
        break;
      end
      @(posedge clk); #1;
    end
    chk("run_ends_in_bound", int'(idle_at > 0), 1);
    @(posedge clk); #1;
    coef_ready = 1'b1;
  endtask
  task automatic clear_phase();
    n = 0; ocnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
      if (dl_zero) n++;
      if (out_valid) ocnt++;
      @(posedge clk); #1;
    end
    chk("clear_cycles", n, 61);
    chk("clear_no_out_valid", ocnt, 0);
    chk("idle_after_clear", busy, 0);
    @(posedge clk); #1;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1);
    chk("rst_dl_wren", dl_wren, 1);
    chk("rst_dl_zero", dl_zero, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_acc_en", acc_en, 0);
    chk("rst_overrun", overrun, 0);
    reset = 1'b0;
    clear_phase();
    one(0);
    chk("s0_waddr", wa1, 0);
    chk("s0_latency", lat, 65);
    chk("s0_out_count", ocnt, 1);
    chk("s0_acc_first", afirst, 4);
    chk("s0_acc_count", an, 61);
    chk("s0_idle_at", idle_at, 66);
    chk("s0_rd_k0", rd[2], 0);
    chk("s0_rd_k1", rd[3], 60);
    chk("s0_rd_k60", rd[62], 1);
    chk("s0_cf_k0", cf[2], 0);
    chk("s0_cf_k60", cf[62], 60);
    for (int s = 1; s <= 61; s++) begin
      one(0);
      chk("seq_waddr", wa1, s % 61);
      chk("seq_latency", lat, 65);
      if (s == 5) begin
        chk("w5_rd_k0", rd[2], 5);
        chk("w5_rd_k5", rd[7], 0);
        chk("w5_rd_k6", rd[8], 60);
        chk("w5_rd_k60", rd[62], 6);
      end
    end
    sample_valid = 1'b1;
    ac = 0; ov = 0; ocnt = 0;
    for (int i = 0; i < 210; i++) begin
      @(negedge clk);
      ac += int'(acc_clr);
      ov += int'(overrun);
      ocnt += int'(out_valid);
      @(posedge clk); #1;
      if (i == 197) sample_valid = 1'b0;
    end
    chk("held_accepts", ac, 3);
    chk("held_out_valid", ocnt, 3);
    chk("held_overruns", ov, 195);
    one(20);
    chk("abort_out_valid", ocnt, 0);
    chk("abort_idle_at", idle_at, 21);
    chk("abort_acc_count", an, 17);
    prev = wa1;
    one(0);
    chk("after_abort_waddr", wa1, (prev + 1) % 61);
    chk("after_abort_latency", lat, 65);
    coef_ready = 1'b0;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    @(negedge clk);
    chk("nocoef_overrun", overrun, 0);
    chk("nocoef_busy", busy, 0);
    @(posedge clk); #1;
    coef_ready = 1'b1;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    chk("pre_rst_acc_en", acc_en, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_acc_en", acc_en, 0);
    chk("midrst_acc_clr", acc_clr, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 1);
    chk("midrst_dl_wren", dl_wren, 1);
    chk("midrst_dl_zero", dl_zero, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    clear_phase();
    one(0);
    chk("post_rst_waddr", wa1, 0);
    chk("post_rst_latency", lat, 65);
    chk("post_rst_out_count", ocnt, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
